// File: rtl/axi4_default_slave.sv
// AXI4 default slave: answers every unmapped/denied burst with DECERR and
// keeps saturating counts of the write and read bursts it has absorbed.
module axi4_default_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // write address
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // write response
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // read address
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    // read data
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    // error statistics
    output logic [CNT_WIDTH-1:0]    wr_err_count,
    output logic [CNT_WIDTH-1:0]    rd_err_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [1:0]           DECERR  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;

    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic [ID_WIDTH-1:0]   bid_q,     bid_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q,  wr_cnt_d;

    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic                  rlast_q,   rlast_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [ID_WIDTH-1:0]   rid_q,     rid_d;
    logic [7:0]            arlen_q,   arlen_d;
    logic [7:0]            beat_q,    beat_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q,  rd_cnt_d;

    // Address, length and payload are accepted but intentionally not used.
    logic unused_inputs;
    assign unused_inputs = ^{awaddr, awlen, wdata, wstrb, araddr};

    // Handshakes qualify on the registered readys, so nothing is accepted
    // until the first edge after reset release.
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        wr_cnt_d  = wr_cnt_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    bid_d     = awid;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q && wlast) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    w_state_d = W_IDLE;
                    if (wr_cnt_q != '1) begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = bvalid_d ? DECERR : 2'b00;
    end

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        arlen_d   = arlen_q;
        beat_d    = beat_q;
        rlast_d   = rlast_q;
        rd_cnt_d  = rd_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    rid_d     = arid;
                    arlen_d   = arlen;
                    beat_d    = '0;
                    rlast_d   = (arlen == 8'd0);
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                        if (rd_cnt_q != '1) begin
                            rd_cnt_d = rd_cnt_q + CNT_ONE;
                        end
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        rlast_d = ((beat_q + 8'd1) == arlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rresp_d   = rvalid_d ? DECERR : 2'b00;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            wr_cnt_q  <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= '0;
            rid_q     <= '0;
            arlen_q   <= '0;
            beat_q    <= '0;
            rd_cnt_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            wr_cnt_q  <= wr_cnt_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            arlen_q   <= arlen_d;
            beat_q    <= beat_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    assign awready      = awready_q;
    assign wready       = wready_q;
    assign bvalid       = bvalid_q;
    assign bresp        = bresp_q;
    assign bid          = bid_q;
    assign arready      = arready_q;
    assign rvalid       = rvalid_q;
    assign rlast        = rlast_q;
    assign rresp        = rresp_q;
    assign rid          = rid_q;
    assign rdata        = '0;
    assign wr_err_count = wr_cnt_q;
    assign rd_err_count = rd_cnt_q;

endmodule

// File: tb/tb_axi4_default_slave.sv
// Directed bench for axi4_default_slave, built with 4-bit error counters.
module tb_axi4_default_slave;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  wr_err_count;
    logic [3:0]  rd_err_count;

    int errors = 0;
    int checks = 0;
    int wr_n   = 0;

    axi4_default_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .CNT_WIDTH (4)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .awid        (awid),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .wvalid      (wvalid),
        .wready      (wready),
        .bid         (bid),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready),
        .wr_err_count(wr_err_count),
        .rd_err_count(rd_err_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge aclk);
    endtask

    task automatic do_write(input logic [3:0] id);
        awvalid = 1'b1; awid = id;
        step();
        awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1; wdata = 32'hA5A5_0000 | 32'(id);
        step();
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        check("sat_bvalid", 32'(bvalid), 32'd1);
        step();
        bready = 1'b0;
        wr_n++;
        check("sat_wr_count", 32'(wr_err_count), (wr_n > 15) ? 32'd15 : 32'(wr_n));
    endtask

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '1; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        // reset state
        step(); step();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_counts",  32'({wr_err_count, rd_err_count}), 32'd0);
        aresetn = 1'b1;
        step();
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);

        // single write
        awvalid = 1'b1; awid = 4'd5; awlen = 8'd0; awaddr = 32'hDEAD_0000;
        step();
        awvalid = 1'b0;
        check("wr1_awready_low", 32'(awready), 32'd0);
        check("wr1_wready",      32'(wready),  32'd1);
        wvalid = 1'b1; wlast = 1'b1; wdata = 32'h1234_5678;
        step();
        wvalid = 1'b0; wlast = 1'b0;
        check("wr1_wready_low", 32'(wready), 32'd0);
        check("wr1_bvalid",     32'(bvalid), 32'd1);
        check("wr1_bid",        32'(bid),    32'd5);
        check("wr1_bresp",      32'(bresp),  32'd3);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("wr1_bvalid_low", 32'(bvalid),       32'd0);
        check("wr1_awready",    32'(awready),      32'd1);
        check("wr1_count",      32'(wr_err_count), 32'd1);
        wr_n = 1;

        // read burst, 8 beats back to back
        arvalid = 1'b1; arid = 4'd3; arlen = 8'd7; rready = 1'b1;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("rd1_rvalid",  32'(rvalid),  32'd1);
            check("rd1_rid",     32'(rid),     32'd3);
            check("rd1_rdata",   rdata,        32'd0);
            check("rd1_rresp",   32'(rresp),   32'd3);
            check("rd1_rlast",   32'(rlast),   (i == 7) ? 32'd1 : 32'd0);
            check("rd1_arready", 32'(arready), 32'd0);
            step();
        end
        rready = 1'b0;
        check("rd1_rvalid_low", 32'(rvalid),       32'd0);
        check("rd1_arready_up", 32'(arready),      32'd1);
        check("rd1_count",      32'(rd_err_count), 32'd1);

        // read with rready toggling: stall cycle then accept cycle per beat
        arvalid = 1'b1; arid = 4'd10; arlen = 8'd3;
        step();
        arvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rready = 1'b0;
            check("bp_rvalid",       32'(rvalid), 32'd1);
            check("bp_rlast",        32'(rlast),  (b == 3) ? 32'd1 : 32'd0);
            step();
            check("bp_hold_rvalid",  32'(rvalid), 32'd1);
            check("bp_hold_rlast",   32'(rlast),  (b == 3) ? 32'd1 : 32'd0);
            check("bp_hold_rid",     32'(rid),    32'd10);
            check("bp_hold_rresp",   32'(rresp),  32'd3);
            rready = 1'b1;
            step();
        end
        rready = 1'b0;
        check("bp_rd_done",  32'(rvalid),       32'd0);
        check("bp_rd_count", 32'(rd_err_count), 32'd2);

        // two-beat write with bready held low for 5 cycles
        awvalid = 1'b1; awid = 4'd9; awlen = 8'd1;
        step();
        awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b0;
        step();
        wlast = 1'b1;
        step();
        wvalid = 1'b0; wlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_hold", 32'(bvalid), 32'd1);
            check("bp_bid_hold",    32'(bid),    32'd9);
            step();
        end
        check("bp_wr_count_pending", 32'(wr_err_count), 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bp_bvalid_low", 32'(bvalid),       32'd0);
        check("bp_wr_count",   32'(wr_err_count), 32'd2);
        wr_n = 2;

        // W presented before AW must stall, not be consumed
        wvalid = 1'b1; wlast = 1'b1;
        step();
        check("wfirst_wready", 32'(wready), 32'd0);
        step();
        check("wfirst_bvalid", 32'(bvalid), 32'd0);
        awvalid = 1'b1; awid = 4'd1;
        step();
        awvalid = 1'b0;
        check("wfirst_wready_up", 32'(wready), 32'd1);
        step();
        wvalid = 1'b0; wlast = 1'b0;
        check("wfirst_bvalid_up", 32'(bvalid), 32'd1);
        check("wfirst_bid",       32'(bid),    32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("wfirst_count", 32'(wr_err_count), 32'd3);
        wr_n = 3;

        // concurrent write (4 beats) and read (4 beats, one initial stall)
        awvalid = 1'b1; awid = 4'd2; awlen = 8'd3;
        arvalid = 1'b1; arid = 4'd6; arlen = 8'd3;
        bready = 1'b1; rready = 1'b0;
        check("cc_awready", 32'(awready), 32'd1);
        check("cc_arready", 32'(arready), 32'd1);
        step();
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b1; wlast = 1'b0;
        check("cc_wready", 32'(wready), 32'd1);
        check("cc_rvalid", 32'(rvalid), 32'd1);
        step();
        rready = 1'b1;
        step();
        step();
        wlast = 1'b1;
        check("cc_rlast_early", 32'(rlast), 32'd0);
        step();
        wvalid = 1'b0; wlast = 1'b0;
        check("cc_bvalid", 32'(bvalid), 32'd1);
        check("cc_bid",    32'(bid),    32'd2);
        check("cc_rlast",  32'(rlast),  32'd1);
        check("cc_rid",    32'(rid),    32'd6);
        check("cc_counts_before", 32'({wr_err_count, rd_err_count}), 32'h32);
        step();
        bready = 1'b0; rready = 1'b0;
        check("cc_bvalid_low", 32'(bvalid), 32'd0);
        check("cc_rvalid_low", 32'(rvalid), 32'd0);
        check("cc_counts_after", 32'({wr_err_count, rd_err_count}), 32'h43);
        wr_n = 4;

        // saturation: writes up to 17 in total
        while (wr_n < 17) begin
            do_write(4'(wr_n));
        end
        check("sat_final", 32'(wr_err_count), 32'hF);

        // reset asserted during read beat 2 of a 6-beat burst
        arvalid = 1'b1; arid = 4'd4; arlen = 8'd5; rready = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        step();
        check("abort_rvalid_before", 32'(rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        check("abort_rvalid",  32'(rvalid),  32'd0);
        check("abort_arready", 32'(arready), 32'd0);
        check("abort_counts",  32'({wr_err_count, rd_err_count}), 32'd0);
        step();
        aresetn = 1'b1; rready = 1'b0;
        step();
        check("abort_arready_up", 32'(arready), 32'd1);
        check("abort_awready_up", 32'(awready), 32'd1);
        check("abort_rvalid_idle", 32'(rvalid), 32'd0);
        arvalid = 1'b1; arid = 4'd7; arlen = 8'd0; rready = 1'b1;
        step();
        arvalid = 1'b0;
        check("post_abort_rvalid", 32'(rvalid), 32'd1);
        check("post_abort_rlast",  32'(rlast),  32'd1);
        check("post_abort_rid",    32'(rid),    32'd7);
        step();
        rready = 1'b0;
        check("post_abort_done",  32'(rvalid),       32'd0);
        check("post_abort_count", 32'(rd_err_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
